// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Holds the receiver state encoding, the cfg_parity and cfg_dbits
// encodings, and small helpers that decode the captured frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HI
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_t;

  typedef enum logic [1:0] {
    DBITS_5 = 2'd0,
    DBITS_6 = 2'd1,
    DBITS_7 = 2'd2,
    DBITS_8 = 2'd3
  } dbits_t;

  // Index of the final data bit: 4 for 5-bit frames up to 7 for 8-bit frames.
  function automatic logic [2:0] last_data_idx(input dbits_t d);
    return 3'd4 + {1'b0, d};
  endfunction

  function automatic logic parity_enabled(input parity_t p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample timebase for the UART receiver.
// Divides clk by cfg_div+1 into oversample ticks and counts OSR ticks
// per bit. clear restarts both counters so a bit period starts exactly at
// start detection.
//   clk, rst          clock, async active-high reset
//   clear             restart divider and sample counter
//   cfg_div           tick period minus one
//   vote_a/b/c        tick at samples OSR/2-2, OSR/2, OSR/2+2
//   bit_end           tick at sample OSR-1
module uart_os_tick #(
  parameter int unsigned OSR   = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             vote_a,
  output logic             vote_b,
  output logic             vote_c,
  output logic             bit_end
);

  localparam int unsigned SW = $clog2(OSR);
  localparam logic [SW-1:0] SAMP_A    = SW'(OSR / 2 - 2);
  localparam logic [SW-1:0] SAMP_B    = SW'(OSR / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OSR / 2 + 2);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OSR - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [SW-1:0]    samp_cnt;
  logic             tick;

  // >= rather than == so a shrinking cfg_div cannot strand the divider
  // above the new wrap value.
  assign tick = (div_cnt >= cfg_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (clear) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SW'(1);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  assign vote_a  = tick && (samp_cnt == SAMP_A);
  assign vote_b  = tick && (samp_cnt == SAMP_B);
  assign vote_c  = tick && (samp_cnt == SAMP_C);
  assign bit_end = tick && (samp_cnt == SAMP_LAST);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with 5..8 data bits, optional even/odd parity,
// 1 or 2 stop bits and per-frame parity/framing/break status.
//   clk, rst                     clock, async active-high reset
//   cfg_div                      oversample tick period minus one
//   cfg_rxen                     enables start detection
//   cfg_dbits/parity/nstop       frame format, captured at start
//   rx_valid                     one-cycle frame-complete strobe
//   rx_data, rx_perr, rx_ferr,   frame results, updated with rx_valid
//   rx_break
//   uart_rxd                     asynchronous serial input, idle high
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned OSR   = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_rxen,
  input  logic [1:0]       cfg_dbits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_nstop,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_break,
  input  logic             uart_rxd
);

  state_t     state, state_next;

  logic       rxd_meta, rxd_sync;
  logic       vote_a, vote_b, vote_c, bit_end;
  logic [2:0] samples;
  logic       vote;

  dbits_t     dbits_q;
  parity_t    par_q;
  logic       nstop_q;
  logic [7:0] data_q;
  logic [2:0] data_cnt;
  logic       par_bit;
  logic       stop_cnt;
  logic       ferr_acc;

  logic       start_det;
  logic       frame_done;
  logic       ferr_final;
  logic       perr_calc;
  logic       break_calc;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  uart_os_tick #(
    .OSR   (OSR),
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_det),
    .cfg_div (cfg_div),
    .vote_a  (vote_a),
    .vote_b  (vote_b),
    .vote_c  (vote_c),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= 3'b111;
    end else begin
      if (vote_a) samples[0] <= rxd_sync;
      if (vote_b) samples[1] <= rxd_sync;
      if (vote_c) samples[2] <= rxd_sync;
    end
  end

  assign vote = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                (samples[1] & samples[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    frame_done = 1'b0;
    ferr_final = ferr_acc | ~vote;
    perr_calc  = parity_enabled(par_q) &&
                 ((^data_q ^ par_bit) != (par_q == PAR_ODD));
    break_calc = ferr_final && (data_q == '0) &&
                 (!parity_enabled(par_q) || !par_bit);
    case (state)
      ST_IDLE: begin
        if (!rxd_sync && cfg_rxen) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_next = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (data_cnt == last_data_idx(dbits_q)))
          state_next = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end && (stop_cnt == nstop_q)) begin
          frame_done = 1'b1;
          state_next = ferr_final ? ST_WAIT_HI : ST_IDLE;
        end
      end
      ST_WAIT_HI: begin
        if (rxd_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame is assembled in data_q so the output registers hold the previous
  // result until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbits_q  <= DBITS_5;
      par_q    <= PAR_NONE;
      nstop_q  <= 1'b0;
      data_q   <= '0;
      data_cnt <= '0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      ferr_acc <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_det) begin
        dbits_q  <= dbits_t'(cfg_dbits);
        par_q    <= parity_t'(cfg_parity);
        nstop_q  <= cfg_nstop;
        data_q   <= '0;
        data_cnt <= '0;
        par_bit  <= 1'b0;
        stop_cnt <= 1'b0;
        ferr_acc <= 1'b0;
      end else if (bit_end) begin
        case (state)
          ST_DATA: begin
            data_q[data_cnt] <= vote;
            data_cnt         <= data_cnt + 3'd1;
          end
          ST_PARITY: par_bit <= vote;
          ST_STOP: begin
            if (frame_done) begin
              rx_valid <= 1'b1;
              rx_data  <= data_q;
              rx_perr  <= perr_calc;
              rx_ferr  <= ferr_final;
              rx_break <= break_calc;
            end else begin
              stop_cnt <= 1'b1;
              ferr_acc <= ferr_acc | ~vote;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext at OSR=16, cfg_div=3 (64 clocks/bit).
module tb_uart_rx_ext;

  localparam int BIT = 64;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_div;
  logic        cfg_rxen;
  logic [1:0]  cfg_dbits;
  logic [1:0]  cfg_parity;
  logic        cfg_nstop;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_ferr;
  logic        rx_break;
  logic        uart_rxd;

  uart_rx_ext #(
    .OSR   (16),
    .DIV_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div    (cfg_div),
    .cfg_rxen   (cfg_rxen),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_nstop  (cfg_nstop),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_perr    (rx_perr),
    .rx_ferr    (rx_ferr),
    .rx_break   (rx_break),
    .uart_rxd   (uart_rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         due;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] h_data;
  logic       h_perr, h_ferr, h_brk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame bit vector, LSB first: start, data, optional parity, stop(s).
  function automatic logic [11:0] build(input logic [7:0] d, input int n, input int par,
                                        input int ns, input logic pb, input logic s1,
                                        input logic s2);
    logic [11:0] b;
    int idx;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < n; i++) b[1 + i] = d[i];
    idx = 1 + n;
    if (par == 1 || par == 2) begin
      b[idx] = pb;
      idx++;
    end
    b[idx] = s1;
    if (ns == 2) b[idx + 1] = s2;
    return b;
  endfunction

  // Frame outcome derived from the line bits and the frame format alone.
  function automatic exp_t model(input logic [11:0] b, input int n, input int par,
                                 input int ns, input int c0);
    exp_t e;
    int p, s0, ones;
    logic pb;
    p  = (par == 1 || par == 2) ? 1 : 0;
    e.data = 8'h00;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      e.data[i] = b[1 + i];
      if (b[1 + i]) ones++;
    end
    pb = b[1 + n];
    s0 = 1 + n + p;
    e.ferr = !b[s0] || (ns == 2 && !b[s0 + 1]);
    if (p == 0)        e.perr = 1'b0;
    else if (par == 1) e.perr = ((ones + pb) % 2) != 0;
    else               e.perr = ((ones + pb) % 2) != 1;
    e.brk = e.ferr && (e.data == 8'h00) && (p == 0 || !pb);
    e.due = c0 + 3 + BIT * (1 + n + p + ns);
    return e;
  endfunction

  task automatic idle(input int k);
    @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (k - 1) @(posedge clk);
  endtask

  // scramble: change every format input and drop rxen after the start bit.
  task automatic frame(input logic [7:0] d, input int n, input int par, input int ns,
                       input logic pb, input logic s1, input logic s2, input bit scramble);
    logic [11:0] b;
    int len, c0;
    logic [1:0] sv_db, sv_par;
    logic sv_ns, sv_en;
    cfg_dbits  = 2'(n - 5);
    cfg_parity = 2'(par);
    cfg_nstop  = (ns == 2);
    sv_db = cfg_dbits; sv_par = cfg_parity; sv_ns = cfg_nstop; sv_en = cfg_rxen;
    b   = build(d, n, par, ns, pb, s1, s2);
    len = 1 + n + ((par == 1 || par == 2) ? 1 : 0) + ns;
    c0  = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1 uart_rxd = b[i];
      if (i == 0) begin
        c0 = cyc;
        exp_q.push_back(model(b, n, par, ns, c0));
      end
      if (i == 1 && scramble) begin
        cfg_dbits  = ~cfg_dbits;
        cfg_parity = cfg_parity + 2'd1;
        cfg_nstop  = ~cfg_nstop;
        cfg_rxen   = 1'b0;
      end
      repeat (BIT - 1) @(posedge clk);
    end
    cfg_dbits = sv_db; cfg_parity = sv_par; cfg_nstop = sv_ns; cfg_rxen = sv_en;
  endtask

  // Compare process: strobes against the expectation queue, held outputs
  // against the last expected frame, every cycle.
  always @(negedge clk) begin
    if (rst) begin
      h_data = 8'h00; h_perr = 1'b0; h_ferr = 1'b0; h_brk = 1'b0;
      chk("reset_valid", rx_valid, 0);
      chk("reset_data", rx_data, 0);
      chk("reset_status", {rx_perr, rx_ferr, rx_break}, 0);
    end else begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", rx_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.due);
          h_data = e.data; h_perr = e.perr; h_ferr = e.ferr; h_brk = e.brk;
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("missing_strobe", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      chk("rx_data", rx_data, h_data);
      chk("rx_perr", rx_perr, h_perr);
      chk("rx_ferr", rx_ferr, h_ferr);
      chk("rx_break", rx_break, h_brk);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [11:0] b;
    rst = 1'b0; uart_rxd = 1'b1; cfg_div = 16'd3; cfg_rxen = 1'b1;
    cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_nstop = 1'b0;
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    // 8N1 0xA5
    frame(8'hA5, 8, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(BIT);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_status", {rx_perr, rx_ferr, rx_break}, 3'b000);

    // 7E1 0x35 with parity bit 1: four ones + 1 is odd -> parity error
    frame(8'h35, 7, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(BIT);
    chk("t2_data", rx_data, 8'h35);
    chk("t2_status", {rx_perr, rx_ferr, rx_break}, 3'b100);

    // 5O2 0x1F, parity 0, second stop 0 -> framing error only
    frame(8'h1F, 5, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 * BIT);
    chk("t3_data", rx_data, 8'h1F);
    chk("t3_status", {rx_perr, rx_ferr, rx_break}, 3'b010);

    // Break: line low 20 bit times, one strobe only
    cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_nstop = 1'b0;
    @(posedge clk);
    #1 uart_rxd = 1'b0;
    exp_q.push_back(model(12'h000, 8, 0, 1, cyc));
    repeat (20 * BIT - 1) @(posedge clk);
    chk("t4_brk_data", rx_data, 8'h00);
    chk("t4_brk_status", {rx_perr, rx_ferr, rx_break}, 3'b011);
    idle(2 * BIT);
    frame(8'h3C, 8, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(BIT);
    chk("t4_data", rx_data, 8'h3C);
    chk("t4_status", {rx_perr, rx_ferr, rx_break}, 3'b000);

    // 12-clock start glitch is rejected
    @(posedge clk);
    #1 uart_rxd = 1'b0;
    repeat (12) @(posedge clk);
    #1 uart_rxd = 1'b1;
    idle(2 * BIT);
    frame(8'h81, 8, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(BIT);
    chk("t5_data", rx_data, 8'h81);

    // Back-to-back, second frame with format inputs changed mid-frame
    frame(8'h12, 8, 3, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    frame(8'h4B, 6, 1, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(BIT);
    chk("t6_data", rx_data, 8'h0B);
    chk("t6_status", {rx_perr, rx_ferr, rx_break}, 3'b100);

    // Reset during data bit 3 of 8N1 0x5A
    cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_nstop = 1'b0;
    b = build(8'h5A, 8, 0, 1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 uart_rxd = b[i];
      repeat (BIT - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 uart_rxd = b[4];
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t7_rst_data", rx_data, 8'h00);
    chk("t7_rst_valid", rx_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    uart_rxd = 1'b1;
    idle(2 * BIT);
    frame(8'h5A, 8, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2 * BIT);
    chk("t7_data", rx_data, 8'h5A);
    chk("t7_status", {rx_perr, rx_ferr, rx_break}, 3'b000);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver. Second generation of the receive path: programmable data length (5–8), optional even/odd parity, 1 or 2 stop bits, parametrised oversampling, and per-frame parity/framing/break status. Sits between the pad-side `uart_rxd` input and the register/FIFO layer, which consumes single-cycle `rx_valid` strobes.

## Interface

Parameters:
- `OSR`, 16: oversampling ratio, ticks per bit; even, 8..32.
- `DIV_W`, 16: width of `cfg_div`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_div`  in  DIV_W  oversample tick period minus one; tick every `cfg_div+1` clocks.
- `cfg_rxen`  in  1  receiver enable; gates new start detection only.
- `cfg_dbits`  in  2  data bits: 0=5, 1=6, 2=7, 3=8.
- `cfg_parity`  in  2  0=none, 1=even, 2=odd, 3=none.
- `cfg_nstop`  in  1  0=one stop bit, 1=two.
- `rx_valid`  out  1  one-cycle frame-complete strobe.
- `rx_data`  out  8  received data, right-justified, unused MSBs 0.
- `rx_perr`  out  1  parity error; valid with `rx_valid`.
- `rx_ferr`  out  1  framing error; valid with `rx_valid`.
- `rx_break`  out  1  break detected; valid with `rx_valid`.
- `uart_rxd`  in  1  asynchronous serial input, idle high.

## Operation

- 2-flop synchroniser on `uart_rxd`, reset value 2'b11 (line idle); all logic uses the synchronised signal.
- Tick generator: divider counts 0..`cfg_div`, emits tick on wrap; sample counter 0..OSR-1 advances per tick. Both cleared when a start is detected in IDLE.
- Per-bit majority vote of samples at ticks OSR/2-2, OSR/2, OSR/2+2; bit decision at tick OSR-1 (bit end).
- `cfg_dbits`, `cfg_parity`, `cfg_nstop` captured on start detection; mid-frame changes are ignored.
- States:
  - IDLE: sync line low and `cfg_rxen` -> START.
  - START: at bit end, vote 0 -> DATA; vote 1 -> IDLE (glitch rejected, no strobe).
  - DATA: vote written to `rx_data[data_cnt]`; after bit `n-1` -> PARITY if parity enabled, else STOP.
  - PARITY: vote stored; -> STOP.
  - STOP: one or two bits; each stop bit voted 0 sets frame `ferr`. After last stop bit: strobe outputs; -> IDLE if `ferr`=0, else -> WAIT_HI.
  - WAIT_HI: stay until sync line high, then IDLE. Prevents re-triggering inside a break.
- Parity check: even -> XOR(data bits, parity bit) must be 0; odd -> must be 1; mismatch sets `rx_perr`. Parity disabled -> `rx_perr`=0.
- `rx_break` = `ferr` and all data bits 0 and (parity bit 0 or parity disabled).
- `rx_data`, `rx_perr`, `rx_ferr`, `rx_break` update only with `rx_valid` and hold until the next strobe.
- `cfg_rxen` deasserted mid-frame: current frame completes and strobes normally.

## Timing

- Reset: all outputs 0, state IDLE, counters 0. Applies immediately, including mid-frame; a partial frame is discarded with no strobe.
- Start detection: 2 clocks after the `uart_rxd` falling edge (synchroniser) + 1 clock registering.
- Bit period: `OSR*(cfg_div+1)` clocks. Frame length: `(1+n+p+s)` bit periods.
- `rx_valid` asserts on the clock after the last stop-bit decision tick; high for exactly 1 cycle.
- Back-to-back frames: a start edge arriving in the clock after the IDLE return is accepted. No inter-frame gap is required.
- `cfg_div`=0: tick every clock, legal.

## Structure

- Package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HI), parity encodings, dbits encodings.
- Sub-module `uart_os_tick` (parameters OSR, DIV_W): divider, sample counter, clear input; outputs vote strobes and bit-end strobe.
- Top-level holds the synchroniser, voter, FSM, and data/status registers.

## Test plan

All scenarios use OSR=16, `cfg_div`=3 (64 clocks/bit).

- 8N1, 0xA5 -> one `rx_valid` pulse; `rx_data`=0xA5; `perr`/`ferr`/`break`=0.
- 7E1, data 0x35 sent with parity bit 1 -> `rx_data`=0x35, `rx_perr`=1, `rx_ferr`=0.
- 5O2, data 0x1F, parity 0, second stop bit 0 -> `rx_data`=0x1F, `rx_perr`=0, `rx_ferr`=1.
- Line low for 20 bit times, then high, then 8N1 0x3C -> first strobe: `rx_data`=0x00, `rx_ferr`=1, `rx_break`=1. No further strobe while low. Second strobe: 0x3C, clean.
- Start glitch low for 12 clocks -> no `rx_valid`; following 8N1 0x81 received correctly.
- `rst` pulse during DATA bit 3 -> outputs 0 in the same cycle, no strobe; next 8N1 0x5A received correctly.
